// File: rtl/root_unit.sv
// root_unit: integer cube root (mode 0) or square root (mode 1) of a W-bit
// operand, digit-by-digit restoring method, with exact remainder. All adds
// for the trial term go through an external combinational adder.
module root_unit #(
    parameter int W = 16,
    localparam int C_D = (W + 2) / 3,
    localparam int S_D = (W + 1) / 2,
    localparam int AW  = W + 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [W-1:0]   x_i,
    output logic [S_D-1:0] result,
    output logic [W-1:0]   rem_o,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  sum_in_a,
    output logic [AW-1:0]  sum_in_b,
    input  logic [AW-1:0]  sum_out
);

    localparam int CW = $clog2(S_D);
    // wide enough to hold the trial term shifted by the largest digit weight
    localparam int BW = AW + 3 * C_D;
    localparam logic [CW-1:0] C_LAST = CW'(C_D - 1);
    localparam logic [CW-1:0] S_LAST = CW'(S_D - 1);

    typedef enum logic [3:0] {
        IDLE, SHIFT, INC1, MUL, TRIPLE, DBL, INC2, CMP, FIN
    } state_t;

    state_t          state;
    logic            m;
    logic [S_D-1:0]  y;
    logic [W-1:0]    r;
    logic [AW-1:0]   t, p;
    logic [CW-1:0]   i, j;
    logic [CW+1:0]   sh;
    logic [BW-1:0]   b;
    logic            fit;
    logic [AW-1:0]   ye;

    assign ye = {{(AW - S_D){1'b0}}, y};

    // trial subtrahend t<<s at full precision and the restoring compare
    always_comb begin
        sh  = m ? {1'b0, i, 1'b0} : ({2'b00, i} + {1'b0, i, 1'b0});
        b   = {{(BW - AW){1'b0}}, t} << sh;
        fit = {{(BW - W){1'b0}}, r} >= b;
    end

    // adder operand select; both operands rest at zero when unused
    always_comb begin
        sum_in_a = '0;
        sum_in_b = '0;
        case (state)
            INC1:   begin sum_in_a = ye; sum_in_b = AW'(1); end
            MUL:    begin sum_in_a = t;  sum_in_b = y[j] ? (p << j) : '0; end
            TRIPLE: begin sum_in_a = t;  sum_in_b = t << 1; end
            DBL:    begin sum_in_a = ye; sum_in_b = ye; end
            INC2:   begin sum_in_a = t;  sum_in_b = AW'(1); end
            default: ;
        endcase
    end

    // control FSM with registered outputs; one digit of the root per pass
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            m      <= 1'b0;
            y      <= '0;
            r      <= '0;
            t      <= '0;
            p      <= '0;
            i      <= '0;
            j      <= '0;
            result <= '0;
            rem_o  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    r     <= x_i;
                    m     <= mode;
                    y     <= '0;
                    i     <= mode ? S_LAST : C_LAST;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    y     <= y << 1;
                    state <= m ? DBL : INC1;
                end
                // p = y+1, then t accumulates y*p one partial product per cycle
                INC1: begin
                    p     <= sum_out;
                    t     <= '0;
                    j     <= '0;
                    state <= MUL;
                end
                MUL: begin
                    t <= sum_out;
                    if (j == C_LAST) state <= TRIPLE;
                    else             j     <= j + CW'(1);
                end
                TRIPLE: begin
                    t     <= sum_out;
                    state <= INC2;
                end
                DBL: begin
                    t     <= sum_out;
                    state <= INC2;
                end
                INC2: begin
                    t     <= sum_out;
                    state <= CMP;
                end
                CMP: begin
                    if (fit) begin
                        r <= r - b[W-1:0];
                        y <= y + S_D'(1);
                    end
                    if (i == '0) state <= FIN;
                    else begin
                        i     <= i - CW'(1);
                        state <= SHIFT;
                    end
                end
                FIN: begin
                    result <= y;
                    rem_o  <= r;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_root_unit.sv
// tb_root_unit: directed and regression checks of root_unit at W=16 and W=8
// against an exhaustive-search root model, with literal pins on key cases.
module tb_root_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s16 = 1'b0, m16 = 1'b0;
    logic [15:0] x16 = '0;
    logic [7:0]  res16;
    logic [15:0] rem16;
    logic        busy16, done16;
    logic [17:0] a16, b16, o16;
    assign o16 = a16 + b16;

    logic        s8 = 1'b0, m8 = 1'b0;
    logic [7:0]  x8 = '0;
    logic [3:0]  res8;
    logic [7:0]  rem8;
    logic        busy8, done8;
    logic [9:0]  a8, b8, o8;
    assign o8 = a8 + b8;

    root_unit #(.W(16)) u16 (
        .clk(clk), .rst(rst), .start(s16), .mode(m16), .x_i(x16),
        .result(res16), .rem_o(rem16), .busy(busy16), .done(done16),
        .sum_in_a(a16), .sum_in_b(b16), .sum_out(o16));

    root_unit #(.W(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .mode(m8), .x_i(x8),
        .result(res8), .rem_o(rem8), .busy(busy8), .done(done8),
        .sum_in_a(a8), .sum_in_b(b8), .sum_out(o8));

    typedef struct {
        int unsigned res;
        int unsigned rem;
        int          lat;
        int          scyc;
    } exp_t;

    exp_t q16[$], q8[$];
    exp_t e16, e8;
    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int sc16 = 0, sc8 = 0;
    int unsigned last_res16 = 0, last_rem16 = 0, last_res8 = 0, last_rem8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endfunction

    // largest k with k^n <= x, found by counting upward
    function automatic void model(input int unsigned x, input bit md,
                                  output int unsigned rt, output int unsigned rm);
        longint unsigned k = 0;
        longint unsigned xx = x;
        while ((md ? (k + 1) * (k + 1) : (k + 1) * (k + 1) * (k + 1)) <= xx) k++;
        rt = int'(k);
        rm = int'(xx - (md ? k * k : k * k * k));
    endfunction

    function automatic int lat(input int w, input bit md);
        int cd = (w + 2) / 3;
        int sd = (w + 1) / 2;
        return md ? 4 * sd + 1 : cd * (cd + 5) + 1;
    endfunction

    // single compare process for both instances
    always @(negedge clk) if (rst) begin
        if (done16 && q16.size() != 0) begin
            e16 = q16.pop_front();
            chk("u16 result", res16, e16.res);
            chk("u16 rem", rem16, e16.rem);
            chk("u16 latency", cyc - e16.scyc, e16.lat);
            last_res16 = e16.res;
            last_rem16 = e16.rem;
        end else begin
            chk("u16 done", done16, 0);
            chk("u16 held result", res16, last_res16);
            chk("u16 held rem", rem16, last_rem16);
        end
        chk("u16 busy", busy16, q16.size() != 0);
        if (q16.size() == 0) begin
            chk("u16 idle sum_in_a", a16, 0);
            chk("u16 idle sum_in_b", b16, 0);
        end
        if (done8 && q8.size() != 0) begin
            e8 = q8.pop_front();
            chk("u8 result", res8, e8.res);
            chk("u8 rem", rem8, e8.rem);
            chk("u8 latency", cyc - e8.scyc, e8.lat);
            last_res8 = e8.res;
            last_rem8 = e8.rem;
        end else begin
            chk("u8 done", done8, 0);
            chk("u8 held result", res8, last_res8);
            chk("u8 held rem", rem8, last_rem8);
        end
        chk("u8 busy", busy8, q8.size() != 0);
    end

    // start presented at a negedge; expectation queued once it is sampled
    task automatic go16(input int unsigned x, input bit md);
        exp_t e;
        s16 = 1'b1; x16 = x[15:0]; m16 = md;
        @(posedge clk); #1;
        s16 = 1'b0;
        model(x, md, e.res, e.rem);
        e.lat = lat(16, md); e.scyc = cyc; sc16 = cyc;
        q16.push_back(e);
    endtask

    task automatic go8(input int unsigned x, input bit md);
        exp_t e;
        s8 = 1'b1; x8 = x[7:0]; m8 = md;
        @(posedge clk); #1;
        s8 = 1'b0;
        model(x, md, e.res, e.rem);
        e.lat = lat(8, md); e.scyc = cyc; sc8 = cyc;
        q8.push_back(e);
    endtask

    task automatic wait16(input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done16) break;
        end
        if (k == 200) chk({nm, " timeout"}, done16, 1);
    endtask

    task automatic wait8(input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done8) break;
        end
        if (k == 200) chk({nm, " timeout"}, done8, 1);
    endtask

    initial begin
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy16, 0);
        chk("reset done", done16, 0);
        chk("reset result", res16, 0);
        chk("reset rem", rem16, 0);
        rst = 1'b1;
        @(negedge clk);

        go16(27, 0);     wait16("cbrt 27");
        chk("cbrt 27 result", res16, 3);
        chk("cbrt 27 rem", rem16, 0);
        chk("cbrt 27 latency", cyc - sc16, 67);

        go16(65535, 0);  wait16("cbrt 65535");
        chk("cbrt 65535 result", res16, 40);
        chk("cbrt 65535 rem", rem16, 1535);

        go16(65535, 1);  wait16("sqrt 65535");
        chk("sqrt 65535 result", res16, 255);
        chk("sqrt 65535 rem", rem16, 510);
        chk("sqrt 65535 latency", cyc - sc16, 33);

        go16(0, 1);      wait16("sqrt 0");
        chk("sqrt 0 result", res16, 0);
        chk("sqrt 0 rem", rem16, 0);

        // extra start and operand churn while busy must not disturb the run
        go16(50, 1);
        repeat (3) @(negedge clk);
        s16 = 1'b1; x16 = 16'd99; m16 = 1'b0;
        @(negedge clk);
        s16 = 1'b0;
        repeat (4) begin @(negedge clk); x16 = ~x16; end
        wait16("sqrt 50");
        chk("sqrt 50 result", res16, 7);
        chk("sqrt 50 rem", rem16, 1);

        // abort a cube run mid-flight
        go16(1000, 0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort busy", busy16, 0);
        chk("abort done", done16, 0);
        chk("abort result", res16, 0);
        chk("abort rem", rem16, 0);
        chk("abort sum_in_a", a16, 0);
        chk("abort sum_in_b", b16, 0);
        q16.delete();
        last_res16 = 0; last_rem16 = 0; last_res8 = 0; last_rem8 = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        go16(1000, 0);   wait16("cbrt 1000");
        chk("cbrt 1000 result", res16, 10);
        chk("cbrt 1000 rem", rem16, 0);
        chk("cbrt 1000 latency", cyc - sc16, 67);

        // back-to-back random regression, mixed modes
        for (int n = 0; n < 200; n++) begin
            go16($urandom_range(0, 65535), 1'($urandom_range(0, 1)));
            wait16("random");
        end

        // exhaustive cube sweep on the narrow instance, back-to-back
        for (int x = 0; x < 256; x++) begin
            go8(x, 0);
            wait8("w8 sweep");
            if (x == 0)   chk("w8 latency", cyc - sc8, 25);
            if (x == 26)  begin chk("w8 cbrt 26 result", res8, 2);  chk("w8 cbrt 26 rem", rem8, 18); end
            if (x == 255) begin chk("w8 cbrt 255 result", res8, 6); chk("w8 cbrt 255 rem", rem8, 39); end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
